// File: rtl/jtdsp16_do_seq_if.sv
// Decoder-side bus of the DSP16 do/redo sequencer: loop commands, fetch strobe,
// ROM word in, and the replayed word plus control flags out.
interface jtdsp16_do_seq_if #(
    parameter int KW = 7
);
    logic            do_start;
    logic [KW+3:0]   do_data;
    logic            ifetch;
    logic [15:0]     rom_dout;
    logic [15:0]     cache_dout;
    logic            use_cache;
    logic            pc_hold;
    logic            loop_active;
    logic            fault;

    modport master (
        output do_start,
        output do_data,
        output ifetch,
        output rom_dout,
        input  cache_dout,
        input  use_cache,
        input  pc_hold,
        input  loop_active,
        input  fault
    );

    modport slave (
        input  do_start,
        input  do_data,
        input  ifetch,
        input  rom_dout,
        output cache_dout,
        output use_cache,
        output pc_hold,
        output loop_active,
        output fault
    );
endinterface

// File: rtl/jtdsp16_do_seq.sv
// DSP16 do/redo loop sequencer: captures the loop body on the first pass from ROM,
// then replays it from a small register file while the program counter is held.
module jtdsp16_do_seq #(
    parameter int DEPTH = 15,
    parameter int KW    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    jtdsp16_do_seq_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        REPLAY  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      ni_reg, ni_next;
    logic [KW-1:0]   iter_reg, iter_next;
    logic [3:0]      wcnt_reg, wcnt_next;
    logic [3:0]      rcnt_reg, rcnt_next;
    logic            cache_valid_reg, cache_valid_next;
    logic            fault_reg, fault_next;

    logic [15:0]     mem [DEPTH];
    logic            mem_we;
    logic [3:0]      mem_waddr;

    logic [3:0]      do_ni;
    logic [KW-1:0]   do_k;
    logic [KW-1:0]   k_eff;
    logic            start_do;
    logic            start_redo;
    logic            cap_fetch;
    logic [3:0]      cap_ni;
    logic [3:0]      cap_wcnt;
    logic [KW-1:0]   cap_iter;
    logic            cap_last;

    assign do_ni      = bus.do_data[KW+3:KW];
    assign do_k       = bus.do_data[KW-1:0];
    assign k_eff      = (do_k == '0) ? KW'(1) : do_k;
    assign start_do   = bus.do_start && (state_reg == IDLE) && (do_ni != 4'd0);
    assign start_redo = bus.do_start && (state_reg == IDLE) && (do_ni == 4'd0);

    // A word fetched in the same cycle as the do strobe is the first body word,
    // so the capture step sees the freshly decoded NI/K instead of the registers.
    assign cap_fetch  = bus.ifetch && ((state_reg == CAPTURE) || start_do);
    assign cap_ni     = start_do ? do_ni : ni_reg;
    assign cap_wcnt   = start_do ? 4'd0 : wcnt_reg;
    assign cap_iter   = start_do ? k_eff : iter_reg;
    assign cap_last   = (cap_wcnt == (cap_ni - 4'd1));

    always_comb begin
        state_next       = state_reg;
        ni_next          = ni_reg;
        iter_next        = iter_reg;
        wcnt_next        = wcnt_reg;
        rcnt_next        = rcnt_reg;
        cache_valid_next = cache_valid_reg;
        fault_next       = fault_reg;
        mem_we           = 1'b0;
        mem_waddr        = cap_wcnt;

        unique case (state_reg)
            IDLE: begin
                if (start_do) begin
                    ni_next          = do_ni;
                    iter_next        = k_eff;
                    cache_valid_next = 1'b0;
                    wcnt_next        = 4'd0;
                    state_next       = CAPTURE;
                end else if (start_redo) begin
                    if (cache_valid_reg) begin
                        iter_next  = k_eff;
                        rcnt_next  = 4'd0;
                        state_next = REPLAY;
                    end else begin
                        fault_next = 1'b1;
                    end
                end
            end
            CAPTURE: begin
            end
            REPLAY: begin
                if (bus.ifetch) begin
                    if (rcnt_reg == (ni_reg - 4'd1)) begin
                        rcnt_next = 4'd0;
                        if (iter_reg <= KW'(1)) begin
                            state_next = IDLE;
                        end else begin
                            iter_next = iter_reg - KW'(1);
                        end
                    end else begin
                        rcnt_next = rcnt_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Capture overrides the IDLE decision when the body starts on the strobe cycle
        if (cap_fetch) begin
            mem_we = 1'b1;
            if (cap_last) begin
                cache_valid_next = 1'b1;
                wcnt_next        = 4'd0;
                rcnt_next        = 4'd0;
                if (cap_iter <= KW'(1)) begin
                    iter_next  = cap_iter;
                    state_next = IDLE;
                end else begin
                    iter_next  = cap_iter - KW'(1);
                    state_next = REPLAY;
                end
            end else begin
                wcnt_next = cap_wcnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            ni_reg          <= 4'd0;
            iter_reg        <= '0;
            wcnt_reg        <= 4'd0;
            rcnt_reg        <= 4'd0;
            cache_valid_reg <= 1'b0;
            fault_reg       <= 1'b0;
        end else if (cen) begin
            state_reg       <= state_next;
            ni_reg          <= ni_next;
            iter_reg        <= iter_next;
            wcnt_reg        <= wcnt_next;
            rcnt_reg        <= rcnt_next;
            cache_valid_reg <= cache_valid_next;
            fault_reg       <= fault_next;
        end
    end

    // Body storage carries no reset; stale contents are never visible outside REPLAY
    always_ff @(posedge clk) begin
        if (cen && mem_we) begin
            mem[mem_waddr] <= bus.rom_dout;
        end
    end

    assign bus.use_cache   = (state_reg == REPLAY);
    assign bus.pc_hold     = (state_reg == REPLAY);
    assign bus.loop_active = (state_reg != IDLE);
    assign bus.fault       = fault_reg;
    assign bus.cache_dout  = (state_reg == REPLAY) ? mem[rcnt_reg] : 16'h0000;

endmodule

// File: tb/tb_jtdsp16_do_seq.sv
// Scoreboard bench for the do/redo sequencer: every fetch pushes its expected
// (use_cache, word) pair and a negedge monitor pops and compares.
module tb_jtdsp16_do_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b0;

    jtdsp16_do_seq_if #(.KW(7)) bus ();

    jtdsp16_do_seq #(.DEPTH(15), .KW(7)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        uc;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: each consumed word is compared with the oldest expectation
    always @(negedge clk) begin
        if (rst && cen && bus.ifetch) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL fetch_unexpected: got uc=%b dout=%h expected no fetch",
                         bus.use_cache, bus.cache_dout);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("fetch", {bus.use_cache, bus.pc_hold, bus.cache_dout},
                      {e.uc, e.uc, (e.uc ? e.data : 16'h0000)});
                $display("fetch uc=%b dout=%h exp_uc=%b exp=%h", bus.use_cache,
                         bus.cache_dout, e.uc, e.data);
            end
        end
    end

    // One cen cycle of stimulus; inputs change 1 time unit after the rising edge
    task automatic step(input logic en, input logic st, input logic [10:0] dd,
                        input logic ifx, input logic [15:0] rom,
                        input logic exp_uc, input logic [15:0] exp_data);
        if (ifx && en) q.push_back('{uc: exp_uc, data: exp_data});
        cen          = en;
        bus.do_start = st;
        bus.do_data  = dd;
        bus.ifetch   = ifx;
        bus.rom_dout = rom;
        @(posedge clk);
        #1;
        bus.do_start = 1'b0;
        bus.ifetch   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 11'd0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    endtask

    function automatic logic [10:0] dcmd(input int ni, input int k);
        return {4'(ni), 7'(k)};
    endfunction

    task automatic status(input string name, input logic la, input logic uc, input logic flt);
        check(name, {15'd0, bus.loop_active, bus.use_cache, bus.fault}, {15'd0, la, uc, flt});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w [15];
        bus.do_start = 1'b0;
        bus.do_data  = 11'd0;
        bus.ifetch   = 1'b0;
        bus.rom_dout = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.use_cache, bus.pc_hold, bus.cache_dout},
              {1'b0, 1'b0, 16'h0000});
        status("reset_status", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(2);

        // do NI=3 K=4: capture A,B,C then 3 replays
        w[0] = 16'hA0A0; w[1] = 16'hB1B1; w[2] = 16'hC2C2;
        step(1'b1, 1'b1, dcmd(3, 4), 1'b1, w[0], 1'b0, 16'h0);
        status("cap_active", 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 11'd0, 1'b1, w[1], 1'b0, 16'h0);
        step(1'b1, 1'b0, 11'd0, 1'b1, w[2], 1'b0, 16'h0);
        status("replay_entered", 1'b1, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 3; i++)
                step(1'b1, 1'b0, 11'd0, 1'b1, 16'hDEAD, 1'b1, w[i]);
        status("do3k4_done", 1'b0, 1'b0, 1'b0);

        // do NI=2 K=1: capture only, then redo K=3
        w[0] = 16'h1234; w[1] = 16'h5678;
        step(1'b1, 1'b1, dcmd(2, 1), 1'b1, w[0], 1'b0, 16'h0);
        step(1'b1, 1'b0, 11'd0, 1'b1, w[1], 1'b0, 16'h0);
        status("do2k1_done", 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, dcmd(0, 3), 1'b0, 16'h0, 1'b0, 16'h0);
        status("redo_started", 1'b1, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 2; i++)
                step(1'b1, 1'b0, 11'd0, 1'b1, 16'hBEEF, 1'b1, w[i]);
        status("redo3_done", 1'b0, 1'b0, 1'b0);

        // do NI=1 K=0 completes on the strobe cycle; redo K=0 replays once
        step(1'b1, 1'b1, dcmd(1, 0), 1'b1, 16'h00F1, 1'b0, 16'h0);
        status("do1k0_done", 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, dcmd(0, 0), 1'b0, 16'h0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 11'd0, 1'b1, 16'hFFFF, 1'b1, 16'h00F1);
        status("redo_k0_done", 1'b0, 1'b0, 1'b0);

        // do NI=15 K=2: full depth
        for (int i = 0; i < 15; i++) w[i] = 16'h1000 + 16'(i * 17);
        step(1'b1, 1'b1, dcmd(15, 2), 1'b1, w[0], 1'b0, 16'h0);
        for (int i = 1; i < 15; i++) step(1'b1, 1'b0, 11'd0, 1'b1, w[i], 1'b0, 16'h0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 11'd0, 1'b1, 16'h0BAD, 1'b1, w[i]);
        status("do15_done", 1'b0, 1'b0, 1'b0);

        // Freeze mid-replay with cen low; nested do ignored
        w[0] = 16'h7001; w[1] = 16'h7002; w[2] = 16'h7003;
        step(1'b1, 1'b1, dcmd(3, 2), 1'b1, w[0], 1'b0, 16'h0);
        step(1'b1, 1'b0, 11'd0, 1'b1, w[1], 1'b0, 16'h0);
        step(1'b1, 1'b0, 11'd0, 1'b1, w[2], 1'b0, 16'h0);
        step(1'b1, 1'b0, 11'd0, 1'b1, 16'h0, 1'b1, w[0]);
        step(1'b0, 1'b0, 11'd0, 1'b1, 16'h0, 1'b0, 16'h0);
        step(1'b0, 1'b1, dcmd(0, 4), 1'b0, 16'h0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 11'd0, 1'b0, 16'h0, 1'b0, 16'h0);
        check("freeze_hold", {bus.use_cache, bus.pc_hold, bus.cache_dout}, {1'b1, 1'b1, w[1]});
        step(1'b1, 1'b1, dcmd(5, 2), 1'b1, 16'h0, 1'b1, w[1]);
        step(1'b1, 1'b0, 11'd0, 1'b1, 16'h0, 1'b1, w[2]);
        status("freeze_done", 1'b0, 1'b0, 1'b0);

        // Reset mid-replay, then redo must fault
        w[0] = 16'h9A01; w[1] = 16'h9A02;
        step(1'b1, 1'b1, dcmd(2, 3), 1'b1, w[0], 1'b0, 16'h0);
        step(1'b1, 1'b0, 11'd0, 1'b1, w[1], 1'b0, 16'h0);
        step(1'b1, 1'b0, 11'd0, 1'b1, 16'h0, 1'b1, w[0]);
        rst = 1'b0;
        #1;
        check("midloop_reset", {bus.use_cache, bus.pc_hold, bus.cache_dout},
              {1'b0, 1'b0, 16'h0000});
        status("midloop_reset_status", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 1'b1, dcmd(0, 5), 1'b0, 16'h0, 1'b0, 16'h0);
        status("redo_fault", 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 11'd0, 1'b1, 16'h4444, 1'b0, 16'h0);
        idle(3);
        status("fault_sticky", 1'b0, 1'b0, 1'b1);

        check("queue_empty", 18'(q.size()), 18'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtdsp16_do_seq.md
Name: jtdsp16_do_seq

Overview:
- Sequencer for the DSP16 instruction cache: executes the "do K {NI instructions}" and "redo K" loops.
- In the first pass it captures the NI loop-body words while they are fetched from ROM. It then replays them from internal storage K-1 more times, holding the program counter and blocking interrupts.
- Sits between the ROM/PC (XAAU) and the instruction decoder. Its cache_dout feeds the decoder input mux, selected by use_cache.

Parameters:
- DEPTH, 15, cache entries; the maximum NI.
- KW, 7, width of the iteration count K.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- cen  in  1  clock enable; all state advances only when cen=1.
- do_start  in  1  one-cycle strobe from the decoder on a do or redo instruction.
- do_data  in  11  [10:7]=NI (0 means redo), [6:0]=K.
- ifetch  in  1  a new instruction word is consumed by the decoder this cen cycle.
- rom_dout  in  16  ROM word being fetched.
- cache_dout  out  16  replayed instruction word.
- use_cache  out  1  decoder takes cache_dout instead of rom_dout.
- pc_hold  out  1  freeze the XAAU program counter.
- loop_active  out  1  loop in progress; drives no_int.
- fault  out  1  sticky; set by redo with no valid cache.

Behaviour:
- States: IDLE, CAPTURE, REPLAY.
- Registers: ni (4b), iter (KW), wcnt/rcnt (4b), cache_valid, mem[DEPTH] x 16.
- Reset (rst=0, async):
  - state=IDLE, ni=0, iter=0, counters=0, cache_valid=0, fault=0.
  - All outputs 0, including cache_dout. mem contents are don't-care.
  - Reset mid-loop aborts the loop immediately. There is no resume.
- use_cache = (state==REPLAY).
- pc_hold = (state==REPLAY).
- loop_active = (state!=IDLE).
- cache_dout = mem[rcnt] in REPLAY, else 0. Combinational, zero latency.
- IDLE, do_start with NI!=0:
  - Latch ni=NI and iter=K (K=0 is treated as 1).
  - Clear cache_valid and set wcnt=0, then go to CAPTURE.
  - If ifetch is also high in the same cycle, that word is captured as mem[0] and wcnt=1.
- CAPTURE, on each ifetch:
  - mem[wcnt] <= rom_dout, wcnt++.
  - PC runs normally.
- CAPTURE, on the ifetch with wcnt==ni-1:
  - Set cache_valid=1.
  - If iter<=1, go to IDLE.
  - Else iter <= iter-1, rcnt=0, go to REPLAY.
- REPLAY, on each ifetch: rcnt++.
- REPLAY, on the ifetch with rcnt==ni-1:
  - If iter==1, go to IDLE.
  - Else iter--, rcnt=0.
  - PC remains at the word after the body, so fetch continues there on exit.
- IDLE, do_start with NI==0 (redo):
  - If cache_valid: iter=max(K,1), rcnt=0, go to REPLAY. The replay body is executed K times.
  - If not cache_valid: set fault=1 and stay in IDLE.
- do_start outside IDLE is ignored (nested do is illegal).
- ifetch in IDLE has no effect.
- cen=0 freezes all state; outputs hold their values.
- Widths: iter/K unsigned KW bits; NI unsigned 4 bits, so ni<=DEPTH is guaranteed.
- Total loop passes: do = K (1 capture + K-1 replays); redo = K (replays only).

Test Plan:
- do NI=3,K=4, body A,B,C, ifetch every cycle:
  - Capture takes 3 ifetches with use_cache=0.
  - Then 9 replay words A,B,C,A,B,C,A,B,C with use_cache=pc_hold=1.
  - Then IDLE and loop_active=0.
- do NI=2,K=1:
  - 2 words captured, no replay, back to IDLE, cache_valid=1.
  - A following redo K=3 replays the 2 words 3 times (6 words).
- Redo (NI=0,K=5) straight after reset:
  - fault=1, state IDLE, use_cache=0.
  - fault stays at 1 until reset.
- do NI=15,K=2: all 15 entries captured, then replayed once in order mem[0..14], wcnt/rcnt never exceed 14.
- Mid-REPLAY, ifetch and cen toggle low for 3 cycles:
  - rcnt and cache_dout hold their values.
  - Sequence resumes correctly.
- Mid-REPLAY, assert rst=0 for 1 cycle:
  - Outputs drop to 0 immediately.
  - A following redo sets fault (cache_valid was cleared).
